downsample_2d: RTL

Two-dimensional image decimator for the disparity-filtering path. It reduces a raster-scanned pixel stream by DEC_X horizontally and DEC_Y vertically. In pick mode it forwards the top-left pixel of each DEC_X×DEC_Y block; in average mode it emits the rounded block mean. It sits between the disparity/confidence producers and the downstream filters, and uses a valid/ready stream on both sides.

---
 rtl/downsample_2d_if.sv | 19 +
 rtl/downsample_2d.sv | 131 +++++++++++++
 2 files changed

// File: rtl/downsample_2d_if.sv
// rtl/downsample_2d_if.sv - valid/ready pixel stream interface for downsample_2d
//
// Purpose: one direction of a raster pixel stream.
// Signals:
//   data   pixel value
//   sof    first pixel of a frame, qualified by valid && ready
//   valid  beat valid (driven by master)
//   ready  beat accepted (driven by slave)
interface downsample_2d_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              sof;
  logic              valid;
  logic              ready;

  modport master (output data, output sof, output valid, input ready);
  modport slave  (input data, input sof, input valid, output ready);
endinterface

// File: rtl/downsample_2d.sv
// rtl/downsample_2d.sv - 2D pixel stream decimator (top-left pick or rounded block mean)
//
// Purpose: reduces a raster-scanned frame by DEC_X horizontally and DEC_Y
// vertically. AVERAGE=0 forwards the top-left pixel of every block,
// AVERAGE=1 emits the rounded-half-up mean of every block.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   in_s   input pixel stream (slave): data, sof, valid, ready
//   out_m  decimated output stream (master): registered data/valid; sof unused (0)
module downsample_2d #(
  parameter int DATA_W    = 8,
  parameter int DEC_X     = 2,
  parameter int DEC_Y     = 2,
  parameter int IN_WIDTH  = 240,
  parameter int IN_HEIGHT = 480,
  parameter int AVERAGE   = 1
) (
  input  logic           clk,
  input  logic           reset,
  downsample_2d_if.slave  in_s,
  downsample_2d_if.master out_m
);

  localparam int S      = $clog2(DEC_X * DEC_Y);
  localparam int SUM_W  = DATA_W + S;
  localparam int LOG_DX = $clog2(DEC_X);
  localparam int NCOL   = IN_WIDTH / DEC_X;
  localparam int XW     = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int YW     = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int GW     = (NCOL > 1) ? $clog2(NCOL) : 1;

  localparam logic [XW-1:0]    X_MASK = XW'(DEC_X - 1);
  localparam logic [YW-1:0]    Y_MASK = YW'(DEC_Y - 1);
  localparam logic [XW-1:0]    X_LAST = XW'(IN_WIDTH - 1);
  localparam logic [YW-1:0]    Y_LAST = YW'(IN_HEIGHT - 1);
  // Half an LSB of the final shift; zero when there is no shift at all.
  localparam logic [SUM_W-1:0] RND    = SUM_W'((1 << S) >> 1);

  logic [XW-1:0]     x_q, x_d, x_eff;
  logic [YW-1:0]     y_q, y_d, y_eff;
  logic [SUM_W-1:0]  hacc_q;
  logic [SUM_W-1:0]  line_q [NCOL];
  logic [SUM_W-1:0]  row, col_sum;
  logic [GW-1:0]     gx;
  logic              px_first, px_last, py_first, py_last;
  logic              emit, in_ready, accept;
  logic [DATA_W-1:0] avg_data;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  always_comb begin
    // A start-of-frame beat sits at (0,0) whatever the counters say.
    x_eff    = in_s.sof ? '0 : x_q;
    y_eff    = in_s.sof ? '0 : y_q;
    px_first = (x_eff & X_MASK) == '0;
    px_last  = (x_eff & X_MASK) == X_MASK;
    py_first = (y_eff & Y_MASK) == '0;
    py_last  = (y_eff & Y_MASK) == Y_MASK;
    gx       = GW'(x_eff >> LOG_DX);

    emit = (AVERAGE != 0) ? (px_last && py_last) : (px_first && py_first);
    // sof feeds in_ready through the effective position: a sof beat can turn
    // into an emitting beat and must then respect a stalled output register.
    in_ready = !emit || !out_valid_q || out_m.ready;
    accept   = in_s.valid && in_ready;

    // Running horizontal sum including this pixel; the group's first pixel
    // starts fresh, so row equals the full group sum on its last pixel.
    row      = (px_first ? '0 : hacc_q) + SUM_W'(in_s.data);
    col_sum  = py_first ? row : line_q[gx] + row;
    avg_data = DATA_W'((col_sum + RND) >> S);
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (x_eff == X_LAST) begin
        x_d = '0;
        y_d = (y_eff == Y_LAST) ? '0 : y_eff + YW'(1);
      end else begin
        x_d = x_eff + XW'(1);
        y_d = y_eff;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept && emit) begin
      out_valid_d = 1'b1;
      out_data_d  = (AVERAGE != 0) ? avg_data : in_s.data;
    end else if (out_m.ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q         <= '0;
      y_q         <= '0;
      hacc_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (accept) begin
        hacc_q <= row;
      end
    end
  end

  // Partial column sums; the last row of a block reads but never writes, so
  // with DEC_Y==1 this array has no writers and drops out.
  always_ff @(posedge clk) begin
    if (accept && px_last && !py_last) begin
      line_q[gx] <= col_sum;
    end
  end

  assign in_s.ready  = in_ready;
  assign out_m.data  = out_data_q;
  assign out_m.valid = out_valid_q;
  assign out_m.sof   = 1'b0;

endmodule
